// File: rtl/fork_join_sched.sv
// fork_join_sched: launches one job on a selected set of worker units and
// raises a continuation pulse when the job's join rule (all/any/none) is met.
// Per-worker occupancy is tracked independently of the join rule. Workers
// left running after a join_any stay reserved until their own done arrives.
//
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   fork_valid    - fork request present
//   fork_ready    - request accepted this cycle if fork_valid is high
//   fork_mask     - workers to launch (bit i = worker i)
//   fork_mode     - 00 join_all, 01 join_any, 10 join_none, 11 reserved
//   start         - one-cycle launch pulse per worker
//   done          - one-cycle completion pulse per worker
//   busy          - worker launched and not yet done
//   join_pulse    - one-cycle continuation pulse
//   join_first    - one-hot worker that satisfied join_any (held)
//   elapsed       - start-to-join latency in cycles, saturating (held)
//   err           - sticky: spurious done or reserved-mode request
module fork_join_sched #(
  parameter int N     = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fork_valid,
  output logic             fork_ready,
  input  logic [N-1:0]     fork_mask,
  input  logic [1:0]       fork_mode,
  output logic [N-1:0]     start,
  input  logic [N-1:0]     done,
  output logic [N-1:0]     busy,
  output logic             join_pulse,
  output logic [N-1:0]     join_first,
  output logic [CNT_W-1:0] elapsed,
  output logic             err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [1:0] M_ALL  = 2'b00;
  localparam logic [1:0] M_ANY  = 2'b01;
  localparam logic [1:0] M_NONE = 2'b10;
  localparam logic [1:0] M_RSVD = 2'b11;

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  logic [0:0]       state_reg;
  logic [N-1:0]     pend_reg;
  logic [1:0]       mode_reg;
  logic [CNT_W-1:0] count_reg;

  logic         accept;
  logic [N-1:0] hit;
  logic [N-1:0] hit_low;
  logic         all_done;
  logic         cnt_max;

  // A fork may only claim workers that are not already occupied, including
  // workers still finishing in the background after a join_any.
  assign fork_ready = (state_reg == S_IDLE) && ((busy & fork_mask) == '0) &&
                      (fork_mode != M_RSVD);
  assign accept     = fork_valid && fork_ready;

  assign hit      = done & pend_reg;
  // Two's-complement trick isolates the lowest set bit of hit.
  assign hit_low  = hit & (~hit + ONE_N);
  assign all_done = (pend_reg & ~done) == '0;
  assign cnt_max  = (count_reg == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      pend_reg   <= '0;
      mode_reg   <= M_ALL;
      count_reg  <= '0;
      start      <= '0;
      busy       <= '0;
      join_pulse <= 1'b0;
      join_first <= '0;
      elapsed    <= '0;
      err        <= 1'b0;
    end else begin
      start      <= '0;
      join_pulse <= 1'b0;

      // Occupancy runs independently of the FSM: done frees a worker, accept
      // claims it. Accepted masks are never busy, so the two cannot overlap.
      busy <= (busy & ~done) | (accept ? fork_mask : '0);

      if ((done & ~busy) != '0) begin
        err <= 1'b1;
      end
      if ((state_reg == S_IDLE) && fork_valid && (fork_mode == M_RSVD)) begin
        err <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            start     <= fork_mask;
            pend_reg  <= fork_mask;
            mode_reg  <= fork_mode;
            count_reg <= '0;
            // Nothing to wait for: continue in the same cycle as the launch.
            if ((fork_mode == M_NONE) || (fork_mask == '0)) begin
              join_pulse <= 1'b1;
              join_first <= '0;
              elapsed    <= '0;
            end else begin
              state_reg <= S_WAIT;
            end
          end
        end

        default: begin
          pend_reg <= pend_reg & ~done;
          if ((mode_reg == M_ANY) && (hit != '0)) begin
            join_pulse <= 1'b1;
            join_first <= hit_low;
            elapsed    <= count_reg;
            state_reg  <= S_IDLE;
          end else if ((mode_reg == M_ALL) && all_done) begin
            join_pulse <= 1'b1;
            join_first <= '0;
            elapsed    <= count_reg;
            state_reg  <= S_IDLE;
          end else if (!cnt_max) begin
            count_reg <= count_reg + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fork_join_sched.sv
// Directed testbench for fork_join_sched: two instances, one with the default
// 16-bit counter and one with a 4-bit counter to reach saturation quickly.
module tb_fork_join_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (N=2, CNT_W=16)
  logic        fv;
  logic        fready;
  logic [1:0]  fmask;
  logic [1:0]  fmode;
  logic [1:0]  start;
  logic [1:0]  done;
  logic [1:0]  busy;
  logic        jp;
  logic [1:0]  jfirst;
  logic [15:0] elapsed;
  logic        err;

  // Saturation instance (N=2, CNT_W=4)
  logic        fv4;
  logic        fready4;
  logic [1:0]  fmask4;
  logic [1:0]  fmode4;
  logic [1:0]  start4;
  logic [1:0]  done4;
  logic [1:0]  busy4;
  logic        jp4;
  logic [1:0]  jfirst4;
  logic [3:0]  elapsed4;
  logic        err4;

  int checks = 0;
  int errors = 0;

  fork_join_sched #(.N(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fork_valid(fv), .fork_ready(fready),
    .fork_mask(fmask), .fork_mode(fmode), .start(start), .done(done),
    .busy(busy), .join_pulse(jp), .join_first(jfirst), .elapsed(elapsed),
    .err(err)
  );

  fork_join_sched #(.N(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .fork_valid(fv4), .fork_ready(fready4),
    .fork_mask(fmask4), .fork_mode(fmode4), .start(start4), .done(done4),
    .busy(busy4), .join_pulse(jp4), .join_first(jfirst4), .elapsed(elapsed4),
    .err(err4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; fv = 0; fmask = 0; fmode = 0; done = 0;
    fv4 = 0; fmask4 = 0; fmode4 = 0; done4 = 0;
    tick(); tick();
    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_join", 32'(jp), 0);
    chk("rst_elapsed", 32'(elapsed), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(fready), 1);
    rst = 1'b0;
    tick();

    // join_any, mask 11: worker0 at +20, worker1 at +30
    fv = 1; fmask = 2'b11; fmode = 2'b01; #1;
    chk("any_ready", 32'(fready), 1);
    tick();                                   // start cycle S
    fv = 0;
    chk("any_start", 32'(start), 2'b11);
    chk("any_busy", 32'(busy), 2'b11);
    repeat (20) tick();                       // S+20
    done = 2'b01;
    tick();                                   // S+21
    done = 2'b00;
    chk("any_join", 32'(jp), 1);
    chk("any_first", 32'(jfirst), 2'b01);
    chk("any_elapsed", 32'(elapsed), 20);
    chk("any_busy_tail", 32'(busy), 2'b10);
    tick();                                   // S+22: occupancy
    fv = 1; fmask = 2'b10; fmode = 2'b00; #1;
    chk("occ_ready_busy", 32'(fready), 0);
    fmask = 2'b01; fmode = 2'b10; #1;
    chk("occ_ready_free", 32'(fready), 1);
    tick();                                   // S+23
    fv = 0;
    chk("occ_start", 32'(start), 2'b01);
    chk("occ_busy", 32'(busy), 2'b11);
    tick();                                   // S+24
    done = 2'b01;
    tick();                                   // S+25
    done = 2'b00;
    chk("occ_busy_after", 32'(busy), 2'b10);
    repeat (5) tick();                        // S+30
    done = 2'b10;
    tick();                                   // S+31
    done = 2'b00;
    chk("tail_busy", 32'(busy), 0);
    chk("tail_nojoin", 32'(jp), 0);
    chk("tail_err", 32'(err), 0);

    // join_all, mask 11: worker0 at +20, worker1 at +30
    tick();
    fv = 1; fmask = 2'b11; fmode = 2'b00;
    tick();                                   // S
    fv = 0;
    chk("all_start", 32'(start), 2'b11);
    repeat (20) tick();
    done = 2'b01;
    tick();                                   // S+21
    done = 2'b00;
    chk("all_nojoin_early", 32'(jp), 0);
    chk("all_busy_mid", 32'(busy), 2'b10);
    repeat (9) tick();                        // S+30
    done = 2'b10;
    tick();                                   // S+31
    done = 2'b00;
    chk("all_join", 32'(jp), 1);
    chk("all_first", 32'(jfirst), 0);
    chk("all_elapsed", 32'(elapsed), 30);
    chk("all_busy", 32'(busy), 0);
    tick();
    chk("all_join_onecyc", 32'(jp), 0);

    // join_none, mask 11
    fv = 1; fmask = 2'b11; fmode = 2'b10;
    tick();                                   // S
    fv = 0;
    chk("none_start", 32'(start), 2'b11);
    chk("none_join", 32'(jp), 1);
    chk("none_elapsed", 32'(elapsed), 0);
    chk("none_busy", 32'(busy), 2'b11);
    repeat (2) tick();
    done = 2'b11;
    tick();
    done = 2'b00;
    chk("none_busy_clr", 32'(busy), 0);
    chk("none_nojoin", 32'(jp), 0);

    // join_any, simultaneous done from both workers at +5
    fv = 1; fmask = 2'b11; fmode = 2'b01;
    tick();
    fv = 0;
    repeat (5) tick();
    done = 2'b11;
    tick();
    done = 2'b00;
    chk("sim_join", 32'(jp), 1);
    chk("sim_first", 32'(jfirst), 2'b01);
    chk("sim_busy", 32'(busy), 0);
    chk("sim_elapsed", 32'(elapsed), 5);

    // Zero-latency worker under join_all
    tick();
    fv = 1; fmask = 2'b10; fmode = 2'b00;
    tick();                                   // start cycle
    fv = 0;
    done = 2'b10;
    tick();
    done = 2'b00;
    chk("zero_join", 32'(jp), 1);
    chk("zero_elapsed", 32'(elapsed), 0);
    chk("zero_first", 32'(jfirst), 0);
    chk("zero_busy", 32'(busy), 0);

    // join_any won by worker1, worker0 finishes later
    tick();
    fv = 1; fmask = 2'b11; fmode = 2'b01;
    tick();
    fv = 0;
    repeat (3) tick();
    done = 2'b10;
    tick();                                   // join_pulse cycle
    done = 2'b00;
    chk("any1_first", 32'(jfirst), 2'b10);
    chk("any1_elapsed", 32'(elapsed), 3);
    chk("any1_busy", 32'(busy), 2'b01);
    fmask = 2'b10; fmode = 2'b00; #1;
    chk("b2b_ready", 32'(fready), 1);
    fmask = 2'b00;
    tick();
    done = 2'b01;
    tick();
    done = 2'b00;
    chk("any1_tail_busy", 32'(busy), 0);
    chk("any1_tail_nojoin", 32'(jp), 0);

    // Counter saturation on the 4-bit instance, done after 40 cycles
    fv4 = 1; fmask4 = 2'b01; fmode4 = 2'b00;
    tick();
    fv4 = 0;
    chk("sat_start", 32'(start4), 2'b01);
    repeat (40) tick();
    done4 = 2'b01;
    tick();
    done4 = 2'b00;
    chk("sat_join", 32'(jp4), 1);
    chk("sat_elapsed", 32'(elapsed4), 15);
    chk("sat_err", 32'(err4), 0);

    // Spurious done in IDLE
    tick();
    done = 2'b10;
    tick();
    done = 2'b00;
    chk("spur_err", 32'(err), 1);
    chk("spur_busy", 32'(busy), 0);
    #2 rst = 1'b1; #1;
    chk("err_clr_rst", 32'(err), 0);
    tick();
    rst = 1'b0;
    tick();

    // Reserved mode refused
    fv = 1; fmask = 2'b01; fmode = 2'b11; #1;
    chk("rsvd_ready", 32'(fready), 0);
    tick();
    fv = 0;
    chk("rsvd_start", 32'(start), 0);
    chk("rsvd_busy", 32'(busy), 0);
    chk("rsvd_err", 32'(err), 1);
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Reset mid-WAIT, then a late done
    fv = 1; fmask = 2'b11; fmode = 2'b00;
    tick();
    fv = 0;
    repeat (3) tick();
    chk("mid_busy_pre", 32'(busy), 2'b11);
    #2 rst = 1'b1; #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_join", 32'(jp), 0);
    chk("mid_elapsed", 32'(elapsed), 0);
    chk("mid_err", 32'(err), 0);
    chk("mid_ready", 32'(fready), 1);
    tick();
    rst = 1'b0;
    fmask = 2'b00;
    tick();
    done = 2'b01;
    tick();
    done = 2'b00;
    chk("late_err", 32'(err), 1);
    chk("late_nojoin", 32'(jp), 0);
    chk("late_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
